// File: rtl/can_loader_pkg.sv
// can_loader_pkg: shared constants, state encoding and helpers for the
// CanCore byte-stream loader.
package can_loader_pkg;

  // Command bytes recognised in IDLE.
  localparam logic [7:0] CMD_PROG = 8'h50;
  localparam logic [7:0] CMD_DATA = 8'h44;
  localparam logic [7:0] CMD_GO   = 8'h47;

  // Payload lengths and the width of the payload byte counter.
  localparam int PROG_BYTES = 3;
  localparam int DATA_BYTES = 64;
  localparam int CNT_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_GO      = 3'd5
  } loader_state_t;

  // Counter value of the final payload byte for the frame type.
  function automatic logic [CNT_W-1:0] lastCount(input logic isData);
    return isData ? CNT_W'(DATA_BYTES - 1) : CNT_W'(PROG_BYTES - 1);
  endfunction

endpackage

// File: rtl/can_word_assembler.sv
// can_word_assembler: little-endian byte-lane word register with a payload
// byte counter. Payload byte k lands in bits [8k+7:8k], so a program word
// is simply the low 24 bits. With CAN_LOADER_CHECKSUM_EN defined it also
// keeps the running XOR of every frame byte.
module can_word_assembler
  import can_loader_pkg::*;
#(
  parameter int WORD_W = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cntClear,
  input  logic              shiftEn,
  input  logic [7:0]        byteIn,
`ifdef CAN_LOADER_CHECKSUM_EN
  input  logic              xorLoad,
  input  logic              xorEn,
  output logic [7:0]        xorAcc,
`endif
  output logic [CNT_W-1:0]  count,
  output logic [WORD_W-1:0] wordNext
);

  logic [WORD_W-1:0] word;

  // Word as it will look after this cycle, so a final byte is visible at once.
  always_comb begin
    wordNext = word;
    if (shiftEn) wordNext[{count, 3'b000} +: 8] = byteIn;
  end

  // Payload storage; contents are don't-care until a frame fills them.
  always_ff @(posedge clock) begin
    if (shiftEn) word <= wordNext;
  end

  // Payload byte counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         count <= '0;
    else if (cntClear) count <= '0;
    else if (shiftEn)  count <= count + 1'b1;
  end

`ifdef CAN_LOADER_CHECKSUM_EN
  // Running XOR: seeded by the command byte, folded with every later byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        xorAcc <= '0;
    else if (xorLoad) xorAcc <= byteIn;
    else if (xorEn)   xorAcc <= xorAcc ^ byteIn;
  end
`endif

endmodule

// File: rtl/can_loader.sv
// can_loader: framed byte-stream loader feeding CanCore's program and data
// memory write ports, plus the start pulse. Optional trailing XOR checksum
// on P/D frames is enabled by defining CAN_LOADER_CHECKSUM_EN.
module can_loader
  import can_loader_pkg::*;
#(
  parameter int PROG_ADDR_W = 7,
  parameter int PROG_DATA_W = 20,
  parameter int DATA_ADDR_W = 4,
  parameter int DATA_DATA_W = 512
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  input  logic [7:0]             io_in_bits,
  output logic                   io_in_ready,
  output logic                   io_programMemory_write_en,
  output logic [PROG_ADDR_W-1:0] io_programMemory_write_addr,
  output logic [PROG_DATA_W-1:0] io_programMemory_write_data,
  output logic                   io_dataMemory_write_en,
  output logic [DATA_ADDR_W-1:0] io_dataMemory_write_addr,
  output logic [DATA_DATA_W-1:0] io_dataMemory_write_data,
  output logic                   io_take,
  output logic                   io_error
);

  localparam int ADDR_KEEP_W = (PROG_ADDR_W > DATA_ADDR_W) ? PROG_ADDR_W : DATA_ADDR_W;

  loader_state_t          state;
  logic                   isData;
  logic [ADDR_KEEP_W-1:0] addrReg;
  logic                   accept;
  logic                   lastByte;
  logic                   loadOut;
  logic [CNT_W-1:0]       count;
  logic [DATA_DATA_W-1:0] wordNext;
`ifdef CAN_LOADER_CHECKSUM_EN
  logic [7:0]             xorAcc;
`endif

  assign io_in_ready = (state != ST_WRITE) && (state != ST_GO);
  assign accept      = io_in_valid && io_in_ready;
  assign lastByte    = (count == lastCount(isData));

  assign io_programMemory_write_en = (state == ST_WRITE) && !isData;
  assign io_dataMemory_write_en    = (state == ST_WRITE) && isData;
  assign io_take                   = (state == ST_GO);

  can_word_assembler #(.WORD_W(DATA_DATA_W)) uAssembler (
    .clock    (clock),
    .reset    (reset),
    .cntClear (accept && (state == ST_ADDR)),
    .shiftEn  (accept && (state == ST_PAYLOAD)),
    .byteIn   (io_in_bits),
`ifdef CAN_LOADER_CHECKSUM_EN
    .xorLoad  (accept && (state == ST_IDLE)),
    .xorEn    (accept && ((state == ST_ADDR) || (state == ST_PAYLOAD))),
    .xorAcc   (xorAcc),
`endif
    .count    (count),
    .wordNext (wordNext)
  );

  // Output registers are captured on the edge that enters WRITE.
  always_comb begin
    loadOut = 1'b0;
`ifdef CAN_LOADER_CHECKSUM_EN
    if (accept && (state == ST_CHECK) && (io_in_bits == xorAcc)) loadOut = 1'b1;
`else
    if (accept && (state == ST_PAYLOAD) && lastByte) loadOut = 1'b1;
`endif
  end

  // Frame sequencing and the sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      isData   <= 1'b0;
      io_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if ((io_in_bits == CMD_PROG) || (io_in_bits == CMD_DATA)) begin
              state  <= ST_ADDR;
              isData <= (io_in_bits == CMD_DATA);
            end else if (io_in_bits == CMD_GO) begin
              state <= ST_GO;
            end else begin
              io_error <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (accept) state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
`ifdef CAN_LOADER_CHECKSUM_EN
          if (accept && lastByte) state <= ST_CHECK;
`else
          if (accept && lastByte) state <= ST_WRITE;
`endif
        end
`ifdef CAN_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (loadOut) begin
              state <= ST_WRITE;
            end else begin
              state    <= ST_IDLE;
              io_error <= 1'b1;
            end
          end
        end
`endif
        ST_WRITE: state <= ST_IDLE;
        ST_GO:    state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Address byte latch; only its low bits are ever used.
  always_ff @(posedge clock) begin
    if (accept && (state == ST_ADDR)) addrReg <= io_in_bits[ADDR_KEEP_W-1:0];
  end

  // Write ports hold their last values between strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_programMemory_write_addr <= '0;
      io_programMemory_write_data <= '0;
      io_dataMemory_write_addr    <= '0;
      io_dataMemory_write_data    <= '0;
    end else if (loadOut) begin
      if (isData) begin
        io_dataMemory_write_addr <= addrReg[DATA_ADDR_W-1:0];
        io_dataMemory_write_data <= wordNext;
      end else begin
        io_programMemory_write_addr <= addrReg[PROG_ADDR_W-1:0];
        io_programMemory_write_data <= wordNext[PROG_DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_can_loader.sv
// tb_can_loader: scoreboard bench for can_loader. Expected writes and start
// pulses are queued as frames are driven and checked as the DUT strobes.
// Define CAN_LOADER_CHECKSUM_EN for both bench and RTL to cover checksums.
module tb_can_loader;
  import can_loader_pkg::*;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    logic [1:0]   kind;   // 0 program, 1 data, 2 go
    logic [7:0]   addr;
    logic [511:0] data;
  } sbEntry_t;

  logic         clock;
  logic         reset;
  logic         io_in_valid;
  logic [7:0]   io_in_bits;
  logic         io_in_ready;
  logic         io_programMemory_write_en;
  logic [6:0]   io_programMemory_write_addr;
  logic [19:0]  io_programMemory_write_data;
  logic         io_dataMemory_write_en;
  logic [3:0]   io_dataMemory_write_addr;
  logic [511:0] io_dataMemory_write_data;
  logic         io_take;
  logic         io_error;

  int       nChecks = 0;
  int       nFail   = 0;
  sbEntry_t sbQ[$];
  sbEntry_t mon;

  can_loader dut (
    .clock                       (clock),
    .reset                       (reset),
    .io_in_valid                 (io_in_valid),
    .io_in_bits                  (io_in_bits),
    .io_in_ready                 (io_in_ready),
    .io_programMemory_write_en   (io_programMemory_write_en),
    .io_programMemory_write_addr (io_programMemory_write_addr),
    .io_programMemory_write_data (io_programMemory_write_data),
    .io_dataMemory_write_en      (io_dataMemory_write_en),
    .io_dataMemory_write_addr    (io_dataMemory_write_addr),
    .io_dataMemory_write_data    (io_dataMemory_write_data),
    .io_take                     (io_take),
    .io_error                    (io_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold it until the edge that accepts it.
  task automatic sendByte(input logic [7:0] b);
    int waitCycles = 0;
    io_in_valid = 1'b1;
    io_in_bits  = b;
    while (!io_in_ready && waitCycles < 200) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    if (!io_in_ready) checkVal("ready_timeout", io_in_ready, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    io_in_valid = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic randGap(input int maxGap);
    if (maxGap > 0) idle($urandom_range(maxGap, 0));
  endtask

  // Drive a complete P or D frame and queue the write it must produce.
  task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] addr,
                           input byteQ_t pl, input int maxGap);
    sbEntry_t e;
    logic [7:0] sum;
    e.kind = (cmd == 8'h44) ? 2'd1 : 2'd0;
    e.addr = (cmd == 8'h44) ? (addr & 8'h0F) : (addr & 8'h7F);
    e.data = '0;
    for (int i = 0; i < pl.size(); i++) e.data[8*i +: 8] = pl[i];
    if (cmd != 8'h44) e.data[511:20] = '0;
    sbQ.push_back(e);
    sum = cmd ^ addr;
    sendByte(cmd);
    randGap(maxGap);
    sendByte(addr);
    for (int i = 0; i < pl.size(); i++) begin
      randGap(maxGap);
      sendByte(pl[i]);
      sum = sum ^ pl[i];
    end
`ifdef CAN_LOADER_CHECKSUM_EN
    randGap(maxGap);
    sendByte(sum);
`endif
    checkVal("strobe_after_last",
             (cmd == 8'h44) ? io_dataMemory_write_en : io_programMemory_write_en, 1'b1);
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (io_programMemory_write_en && io_dataMemory_write_en)
        checkVal("dual_strobe", 1'b1, 1'b0);
      if (io_programMemory_write_en || io_dataMemory_write_en || io_take) begin
        if (sbQ.size() == 0) begin
          checkVal("unexpected_strobe",
                   {io_take, io_dataMemory_write_en, io_programMemory_write_en}, 3'b000);
        end else begin
          mon = sbQ.pop_front();
          checkVal("strobe_ready", io_in_ready, 1'b0);
          if (io_take) begin
            checkVal("go_kind", 2'd2, mon.kind);
          end else if (io_programMemory_write_en) begin
            checkVal("prog_kind", 2'd0, mon.kind);
            checkVal("prog_addr", io_programMemory_write_addr, mon.addr);
            checkVal("prog_data", io_programMemory_write_data, mon.data);
          end else begin
            checkVal("data_kind", 2'd1, mon.kind);
            checkVal("data_addr", io_dataMemory_write_addr, mon.addr);
            checkVal("data_data", io_dataMemory_write_data, mon.data);
          end
        end
      end
    end
  end

  initial begin
    byteQ_t   pl;
    sbEntry_t g;
    reset       = 1'b1;
    io_in_valid = 1'b0;
    io_in_bits  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    checkVal("rst_ready", io_in_ready, 1'b1);
    checkVal("rst_prog_en", io_programMemory_write_en, 1'b0);
    checkVal("rst_data_en", io_dataMemory_write_en, 1'b0);
    checkVal("rst_take", io_take, 1'b0);
    checkVal("rst_error", io_error, 1'b0);
    checkVal("rst_prog_addr", io_programMemory_write_addr, 0);
    checkVal("rst_prog_data", io_programMemory_write_data, 0);
    checkVal("rst_data_addr", io_dataMemory_write_addr, 0);
    checkVal("rst_data_data", io_dataMemory_write_data, 0);
    reset = 1'b0;
    idle(2);

    // Program frame, continuous valid.
    pl = '{8'h34, 8'h12, 8'hF6};
    sendFrame(8'h50, 8'h05, pl, 0);
    checkVal("p1_no_error", io_error, 1'b0);

    // Data frame 00..3F straight after, valid never dropped.
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    sendFrame(8'h44, 8'h0F, pl, 0);
    idle(2);
    checkVal("d1_low_byte", io_dataMemory_write_data[7:0], 8'h00);
    checkVal("d1_high_byte", io_dataMemory_write_data[511:504], 8'h3F);

    // Go: one-cycle take, ready low in that cycle.
    g.kind = 2'd2; g.addr = '0; g.data = '0;
    sbQ.push_back(g);
    sendByte(8'h47);
    checkVal("go_take_now", io_take, 1'b1);
    checkVal("go_ready_low", io_in_ready, 1'b0);
    idle(1);
    checkVal("go_one_cycle", io_take, 1'b0);

    // Unknown command sets sticky error; later frames still write.
    sendByte(8'h99);
    checkVal("bad_cmd_error", io_error, 1'b1);
    idle(2);
    pl = '{8'hAA, 8'hBB, 8'hCC};
    sendFrame(8'h50, 8'h85, pl, 3);
    idle(2);
    checkVal("error_sticky", io_error, 1'b1);
    checkVal("prog_hold_addr", io_programMemory_write_addr, 7'h05);
    checkVal("prog_hold_data", io_programMemory_write_data, 20'hCBBAA);

    // Reset in the middle of a data frame drops it.
    sendByte(8'h44);
    sendByte(8'h13);
    sendByte(8'hAA);
    sendByte(8'hBB);
    io_in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checkVal("midrst_error", io_error, 1'b0);
    checkVal("midrst_ready", io_in_ready, 1'b1);
    checkVal("midrst_prog_data", io_programMemory_write_data, 0);
    checkVal("midrst_data_addr", io_dataMemory_write_addr, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(3);
    pl = '{8'h01, 8'h02, 8'h03};
    sendFrame(8'h50, 8'h7F, pl, 0);
    idle(1);

    // Random data frame with random stalls.
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom_range(255, 0)));
    sendFrame(8'h44, 8'($urandom_range(255, 0)), pl, 2);
    idle(2);
    checkVal("no_error_after_reset", io_error, 1'b0);

`ifdef CAN_LOADER_CHECKSUM_EN
    // Wrong checksum: no write, error raised.
    sendByte(8'h50);
    sendByte(8'h01);
    sendByte(8'hAA);
    sendByte(8'hBB);
    sendByte(8'h0C);
    sendByte(8'h00);
    checkVal("cks_bad_no_strobe", io_programMemory_write_en, 1'b0);
    idle(2);
    checkVal("cks_bad_error", io_error, 1'b1);
    pl = '{8'hAA, 8'hBB, 8'h0C};
    sendFrame(8'h50, 8'h01, pl, 0);
    idle(2);
    checkVal("cks_good_data", io_programMemory_write_data, 20'hCBBAA);
`endif

    idle(5);
    checkVal("sb_drained", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
